fetch_hazard_ctrl: RTL and testbench

//  Sequences the fetch->decode pipeline register and the F/D/E boundary: produces StallF, StallD (drives

---
 rtl/fetch_hazard_ctrl_if.sv | 32 +++
 rtl/fetch_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_hazard_ctrl_if.sv
// rtl/fetch_hazard_ctrl_if.sv - hazard-unit signal bundle between the F/D/E pipeline and fetch_hazard_ctrl
interface fetch_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) ();
  logic [REG_ADDR_WIDTH-1:0] Rs1D;
  logic [REG_ADDR_WIDTH-1:0] Rs2D;
  logic [REG_ADDR_WIDTH-1:0] RdE;
  logic                      LoadE;
  logic                      PCSrcE;
  logic                      ICacheMissF;
  logic                      ICacheReadyF;
  logic                      StallF;
  logic                      StallD;
  logic                      FlushD;
  logic                      FlushE;
  logic                      FetchErr;
  logic [CNT_WIDTH-1:0]      StallCount;
  logic [CNT_WIDTH-1:0]      FlushCount;
  logic [CNT_WIDTH-1:0]      MissCount;

  // Pipeline side: supplies hazard sources, consumes stall/flush controls.
  modport master (
    output Rs1D, Rs2D, RdE, LoadE, PCSrcE, ICacheMissF, ICacheReadyF,
    input  StallF, StallD, FlushD, FlushE, FetchErr, StallCount, FlushCount, MissCount
  );

  modport slave (
    input  Rs1D, Rs2D, RdE, LoadE, PCSrcE, ICacheMissF, ICacheReadyF,
    output StallF, StallD, FlushD, FlushE, FetchErr, StallCount, FlushCount, MissCount
  );
endinterface

// File: rtl/fetch_hazard_ctrl.sv
// rtl/fetch_hazard_ctrl.sv - fetch/decode stall and flush sequencing with I-cache miss timeout and perf counters
module fetch_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int MISS_TIMEOUT   = 200,
  parameter int CNT_WIDTH      = 16
) (
  input logic              CLK,
  input logic              RST,
  fetch_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MISS = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(MISS_TIMEOUT - 1);

  state_t                   state, state_nx;
  logic [TIMEOUT_WIDTH-1:0] timeout, timeout_nx;
  logic [CNT_WIDTH-1:0]     stall_cnt, flush_cnt, miss_cnt;
  logic                     lw_stall;
  logic                     stall_f, stall_d, flush_d, flush_e, miss_evt;

  assign lw_stall = hz.LoadE && (hz.RdE != '0) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

  always_comb begin
    state_nx   = state;
    timeout_nx = timeout;
    miss_evt   = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    case (state)
      RUN: begin
        // A taken branch makes the current fetch wrong-path, so its miss is dropped.
        if (hz.PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (hz.ICacheMissF) begin
          stall_f    = 1'b1;
          stall_d    = 1'b1;
          flush_e    = 1'b1;
          state_nx   = MISS;
          timeout_nx = '0;
          miss_evt   = 1'b1;
        end else begin
          stall_f = lw_stall;
          stall_d = lw_stall;
          flush_e = lw_stall;
        end
      end
      MISS: begin
        if (!hz.ICacheReadyF) begin
          stall_f    = 1'b1;
          stall_d    = 1'b1;
          flush_e    = 1'b1;
          timeout_nx = timeout + 1'b1;
          if (timeout == TIMEOUT_LAST) state_nx = ERR;
        end else begin
          stall_f  = lw_stall;
          stall_d  = lw_stall;
          flush_e  = lw_stall;
          state_nx = RUN;
        end
      end
      ERR: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      timeout   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      state   <= state_nx;
      timeout <= timeout_nx;
      if (stall_d && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_d && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      if (miss_evt && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FetchErr   = (state == ERR);
  assign hz.StallCount = stall_cnt;
  assign hz.FlushCount = flush_cnt;
  assign hz.MissCount  = miss_cnt;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// tb/tb_fetch_hazard_ctrl.sv - directed bench for fetch_hazard_ctrl with a behavioural reference model
module tb_fetch_hazard_ctrl;

  localparam int MT   = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic CLK;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  fetch_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) bus ();

  fetch_hazard_ctrl #(
    .REG_ADDR_WIDTH(5),
    .TIMEOUT_WIDTH (8),
    .MISS_TIMEOUT  (MT),
    .CNT_WIDTH     (CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .hz (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: waiting-for-refill flag, dead flag, cycles waited, plain event tallies.
  bit m_waiting, m_dead;
  int m_wait, m_stall, m_flush, m_misses;

  function automatic bit load_use();
    return bus.LoadE && (bus.RdE != 0) && ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
  endfunction

  function automatic void model_out(output bit sf, output bit sd, output bit fd, output bit fe);
    bit lw;
    lw = load_use();
    sf = 0; sd = 0; fd = 0; fe = 0;
    if (m_dead || (m_waiting && !bus.ICacheReadyF)) begin
      sf = 1; sd = 1; fe = 1;
    end else if (m_waiting) begin
      sf = lw; sd = lw; fe = lw;
    end else if (bus.PCSrcE) begin
      fd = 1; fe = 1;
    end else if (bus.ICacheMissF) begin
      sf = 1; sd = 1; fe = 1;
    end else begin
      sf = lw; sd = lw; fe = lw;
    end
  endfunction

  always @(posedge CLK or posedge RST) begin
    bit sf, sd, fd, fe;
    if (RST) begin
      m_waiting = 0; m_dead = 0; m_wait = 0;
      m_stall = 0; m_flush = 0; m_misses = 0;
    end else begin
      model_out(sf, sd, fd, fe);
      if (sd && m_stall < CMAX) m_stall++;
      if (fd && m_flush < CMAX) m_flush++;
      if (m_dead) begin
      end else if (m_waiting) begin
        if (bus.ICacheReadyF) m_waiting = 0;
        else begin
          m_wait++;
          if (m_wait == MT) begin
            m_waiting = 0;
            m_dead = 1;
          end
        end
      end else if (!bus.PCSrcE && bus.ICacheMissF) begin
        m_waiting = 1;
        m_wait = 0;
        if (m_misses < CMAX) m_misses++;
      end
    end
  end

  always @(negedge CLK) begin
    bit sf, sd, fd, fe;
    if (!RST) begin
      model_out(sf, sd, fd, fe);
      check("StallF", int'(bus.StallF), int'(sf));
      check("StallD", int'(bus.StallD), int'(sd));
      check("FlushD", int'(bus.FlushD), int'(fd));
      check("FlushE", int'(bus.FlushE), int'(fe));
      check("FetchErr", int'(bus.FetchErr), int'(m_dead));
      check("StallCount", int'(bus.StallCount), m_stall);
      check("FlushCount", int'(bus.FlushCount), m_flush);
      check("MissCount", int'(bus.MissCount), m_misses);
    end
  end

  task automatic apply(input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic pc, input logic ms, input logic rdy);
    bus.LoadE        = ld;
    bus.RdE          = rd;
    bus.Rs1D         = r1;
    bus.Rs2D         = r2;
    bus.PCSrcE       = pc;
    bus.ICacheMissF  = ms;
    bus.ICacheReadyF = rdy;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    tick();
  endtask

  typedef struct {
    logic       ld;
    logic [4:0] rd, r1, r2;
    logic       stall;
  } lw_vec_t;

  lw_vec_t lw_tab[6];

  initial begin
    lw_tab[0] = '{1, 5'd5,  5'd5, 5'd0,  1};
    lw_tab[1] = '{1, 5'd5,  5'd0, 5'd5,  1};
    lw_tab[2] = '{1, 5'd0,  5'd0, 5'd0,  0};
    lw_tab[3] = '{0, 5'd5,  5'd5, 5'd5,  0};
    lw_tab[4] = '{1, 5'd31, 5'd1, 5'd31, 1};
    lw_tab[5] = '{1, 5'd7,  5'd6, 5'd8,  0};

    idle();
    RST = 1'b1;
    #12;
    RST = 1'b0;
    tick();
    check("reset_stallf", int'(bus.StallF), 0);
    check("reset_count", int'(bus.StallCount), 0);

    // Load-use hazard for one cycle, then a load to x0 that must not stall.
    apply(1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    #1;
    check("lw_stallf", int'(bus.StallF), 1);
    check("lw_flushe", int'(bus.FlushE), 1);
    tick();
    apply(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    #1;
    check("lw_x0_stallf", int'(bus.StallF), 0);
    tick();
    check("lw_stallcount", int'(bus.StallCount), 1);

    foreach (lw_tab[i]) begin
      apply(lw_tab[i].ld, lw_tab[i].rd, lw_tab[i].r1, lw_tab[i].r2, 0, 0, 0);
      #1;
      check($sformatf("lw_tab%0d", i), int'(bus.StallD), int'(lw_tab[i].stall));
      tick();
    end

    // Taken branch flushes D and E without stalling.
    do_reset();
    apply(0, 0, 0, 0, 1, 0, 0);
    #1;
    check("br_flushd", int'(bus.FlushD), 1);
    check("br_stallf", int'(bus.StallF), 0);
    tick();
    idle();
    check("br_flushcount", int'(bus.FlushCount), 1);
    tick();

    // Miss at t0, refill ready at t3.
    do_reset();
    apply(0, 0, 0, 0, 0, 1, 0);
    tick();
    idle();
    tick();
    tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    #1;
    check("miss_release", int'(bus.StallF), 0);
    tick();
    idle();
    check("miss_stallcount", int'(bus.StallCount), 3);
    check("miss_misscount", int'(bus.MissCount), 1);
    tick();

    // Branch and miss together: flush wins, miss is dropped.
    do_reset();
    apply(0, 0, 0, 0, 1, 1, 0);
    tick();
    idle();
    #1;
    check("brmiss_stallf", int'(bus.StallF), 0);
    check("brmiss_misscount", int'(bus.MissCount), 0);
    tick();

    // Refill arrives while a load-use hazard is present: still stalls for the hazard.
    do_reset();
    apply(0, 0, 0, 0, 0, 1, 0);
    tick();
    apply(1, 5'd9, 5'd9, 5'd0, 0, 0, 1);
    #1;
    check("ready_lw_stallf", int'(bus.StallF), 1);
    tick();
    tick();
    idle();
    tick();

    // Miss timeout into sticky error.
    do_reset();
    apply(0, 0, 0, 0, 0, 1, 0);
    tick();
    idle();
    tick();
    tick();
    tick();
    check("timeout_pre_err", int'(bus.FetchErr), 0);
    tick();
    check("timeout_err", int'(bus.FetchErr), 1);
    apply(0, 0, 0, 0, 1, 0, 1);
    tick();
    tick();
    tick();
    check("err_sticky", int'(bus.FetchErr), 1);
    check("err_stallf", int'(bus.StallF), 1);
    check("err_stallcount", int'(bus.StallCount), 8);
    check("err_flushcount", int'(bus.FlushCount), 0);
    do_reset();
    check("err_cleared", int'(bus.FetchErr), 0);

    // Counter saturation.
    apply(1, 5'd3, 5'd3, 5'd3, 0, 0, 0);
    repeat (20) tick();
    check("stall_sat", int'(bus.StallCount), CMAX);
    apply(0, 0, 0, 0, 1, 0, 0);
    repeat (20) tick();
    check("flush_sat", int'(bus.FlushCount), CMAX);

    // Asynchronous reset between edges while waiting on a refill.
    do_reset();
    apply(0, 0, 0, 0, 0, 1, 0);
    tick();
    idle();
    tick();
    check("amiss_stallf", int'(bus.StallF), 1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_stallf", int'(bus.StallF), 0);
    check("arst_fetcherr", int'(bus.FetchErr), 0);
    check("arst_stallcount", int'(bus.StallCount), 0);
    check("arst_misscount", int'(bus.MissCount), 0);
    RST = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
